// File: rtl/index_decoder_32.sv
// index_decoder_32
//   32-entry mark/unmark bitmap with a registered request stage, one-hot
//   decode of the staged request, a population count and a grouped
//   clear-all sequence.
//
//   Parameters
//     SIGNAL     bitmap value that means "marked"; unmarked is ~SIGNAL.
//
//   Ports
//     clk          sole clock, rising edge
//     rst          synchronous, active-high reset
//     in_valid     request present on in_index / in_set
//     in_ready     request accepted at the edge when in_valid && in_ready
//     in_index     entry to update (0..31)
//     in_set       1 = mark entry, 0 = unmark entry
//     clear_all    single-cycle pulse: unmark every entry
//     bitmap       registered entry states (unpacked [31:0])
//     onehot       registered one-hot decode of the staged request
//     count        registered number of marked entries (0..32)
//     all_marked   count == 32
//     none_marked  count == 0
//     busy         FSM not IDLE
//     clear_done   one-cycle pulse when a clear_all sequence completes
//     err          sticky flag for redundant mark/unmark operations
//
//   Build option
//     INDEX_DECODER_ERR_CHECK_EN  when defined, err is implemented and is
//                                 cleared by rst or clear completion; when
//                                 undefined, err is tied low.
module index_decoder_32 #(
   parameter bit SIGNAL = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [4:0]  in_index,
   input  logic        in_set,
   input  logic        clear_all,
   output logic        bitmap [31:0],
   output logic [31:0] onehot,
   output logic [5:0]  count,
   output logic        all_marked,
   output logic        none_marked,
   output logic        busy,
   output logic        clear_done,
   output logic        err
);

   localparam logic MARK   = SIGNAL;
   localparam logic UNMARK = ~SIGNAL;

   typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_e;

   state_e      state_q, state_d;
   logic [1:0]  grp_q, grp_d;
   logic        stg_valid_q, stg_valid_d;
   logic [4:0]  stg_idx_q, stg_idx_d;
   logic        stg_set_q, stg_set_d;
   logic [31:0] onehot_q, onehot_d;
   logic        bitmap_q [31:0];
   logic        bitmap_d [31:0];
   logic [5:0]  count_q, count_d;
   logic        clear_done_q, clear_done_d;
   logic        accept;
   logic        redundant;
   logic        clear_last;
   logic [3:0]  grp_marked;
   logic [4:0]  gidx;

   assign in_ready   = (state_q == IDLE) && !clear_all;
   assign accept     = in_valid && in_ready;
   assign clear_last = (state_q == CLEAR) && (grp_q == 2'd3);

   always_comb begin
      state_d      = state_q;
      grp_d        = grp_q;
      stg_valid_d  = accept;
      stg_idx_d    = stg_idx_q;
      stg_set_d    = stg_set_q;
      onehot_d     = '0;
      bitmap_d     = bitmap_q;
      count_d      = count_q;
      clear_done_d = 1'b0;
      redundant    = 1'b0;
      grp_marked   = '0;
      gidx         = '0;

      if (accept) begin
         stg_idx_d = in_index;
         stg_set_d = in_set;
         onehot_d  = 32'd1 << in_index;
      end

      // Apply the staged request. It reads the registered bitmap, so a
      // back-to-back request to the same index sees the previous result.
      if (stg_valid_q) begin
         if (stg_set_q) begin
            if (bitmap_q[stg_idx_q] == MARK) begin
               redundant = 1'b1;
            end else begin
               bitmap_d[stg_idx_q] = MARK;
               if (count_q != 6'd32) count_d = count_q + 6'd1;
            end
         end else begin
            if (bitmap_q[stg_idx_q] == UNMARK) begin
               redundant = 1'b1;
            end else begin
               bitmap_d[stg_idx_q] = UNMARK;
               if (count_q != 6'd0) count_d = count_q - 6'd1;
            end
         end
      end

      case (state_q)
         IDLE: begin
            if (clear_all) state_d = DRAIN;
         end
         DRAIN: begin
            state_d = CLEAR;
            grp_d   = '0;
         end
         CLEAR: begin
            // The stage register is always empty here (in_ready is low
            // from DRAIN onward), so the group clear owns bitmap/count.
            for (int unsigned i = 0; i < 8; i++) begin
               gidx = {grp_q, 3'(i)};
               if (bitmap_q[gidx] == MARK) begin
                  grp_marked     = grp_marked + 4'd1;
                  bitmap_d[gidx] = UNMARK;
               end
            end
            count_d = (count_q > {2'b00, grp_marked}) ?
                      count_q - {2'b00, grp_marked} : '0;
            grp_d   = grp_q + 2'd1;
            if (grp_q == 2'd3) begin
               state_d      = IDLE;
               clear_done_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         grp_q        <= '0;
         stg_valid_q  <= 1'b0;
         stg_idx_q    <= '0;
         stg_set_q    <= 1'b0;
         onehot_q     <= '0;
         count_q      <= '0;
         clear_done_q <= 1'b0;
         for (int unsigned i = 0; i < 32; i++) bitmap_q[i] <= UNMARK;
      end else begin
         state_q      <= state_d;
         grp_q        <= grp_d;
         stg_valid_q  <= stg_valid_d;
         stg_idx_q    <= stg_idx_d;
         stg_set_q    <= stg_set_d;
         onehot_q     <= onehot_d;
         count_q      <= count_d;
         clear_done_q <= clear_done_d;
         bitmap_q     <= bitmap_d;
      end
   end

`ifdef INDEX_DECODER_ERR_CHECK_EN
   logic err_q;

   always_ff @(posedge clk) begin
      if (rst)             err_q <= 1'b0;
      else if (clear_last) err_q <= 1'b0;
      else if (redundant)  err_q <= 1'b1;
   end

   assign err = err_q;
`else
   logic unused_redundant;
   assign unused_redundant = redundant ^ clear_last;
   assign err = 1'b0;
`endif

   assign bitmap      = bitmap_q;
   assign onehot      = onehot_q;
   assign count       = count_q;
   assign all_marked  = (count_q == 6'd32);
   assign none_marked = (count_q == 6'd0);
   assign busy        = (state_q != IDLE);
   assign clear_done  = clear_done_q;

endmodule

// File: tb/tb_index_decoder_32.sv
// tb_index_decoder_32
//   Directed bench for index_decoder_32. Two instances share all inputs:
//   u_dut1 with SIGNAL=1 and u_dut0 with SIGNAL=0, so both must track the
//   same count while holding complementary bitmaps.
module tb_index_decoder_32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, in_valid, in_set, clear_all;
   logic [4:0]  in_index;
   logic        rdy1, rdy0;
   logic        bm1 [31:0];
   logic        bm0 [31:0];
   logic [31:0] oh1, oh0;
   logic [5:0]  cnt1, cnt0;
   logic        am1, am0, nm1, nm0, busy1, busy0, cd1, cd0, err1, err0;
   logic [31:0] bm1_p, bm0_p;

`ifdef INDEX_DECODER_ERR_CHECK_EN
   localparam logic [31:0] EXP_ERR = 32'd1;
`else
   localparam logic [31:0] EXP_ERR = 32'd0;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   index_decoder_32 #(.SIGNAL(1'b1)) u_dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
      .in_index(in_index), .in_set(in_set), .clear_all(clear_all),
      .bitmap(bm1), .onehot(oh1), .count(cnt1), .all_marked(am1),
      .none_marked(nm1), .busy(busy1), .clear_done(cd1), .err(err1)
   );

   index_decoder_32 #(.SIGNAL(1'b0)) u_dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0),
      .in_index(in_index), .in_set(in_set), .clear_all(clear_all),
      .bitmap(bm0), .onehot(oh0), .count(cnt0), .all_marked(am0),
      .none_marked(nm0), .busy(busy0), .clear_done(cd0), .err(err0)
   );

   always_comb begin
      bm1_p = '0;
      bm0_p = '0;
      for (int i = 0; i < 32; i++) begin
         bm1_p[i] = bm1[i];
         bm0_p[i] = bm0[i];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_set = 1'b0; clear_all = 1'b0;
      in_index = '0;
      tick; tick;

      // Reset state
      chk("rst_ready1", rdy1, 1);
      chk("rst_ready0", rdy0, 1);
      chk("rst_busy", busy1, 0);
      chk("rst_none", nm1, 1);
      chk("rst_all", am1, 0);
      chk("rst_count", cnt1, 0);
      chk("rst_onehot", oh1, 0);
      chk("rst_err", err1, 0);
      chk("rst_cdone", cd1, 0);
      chk("rst_bm1", bm1_p, 32'h0000_0000);
      chk("rst_bm0", bm0_p, 32'hFFFF_FFFF);
      rst = 1'b0;

      // Unmark 9 at reset state: redundant
      in_valid = 1'b1; in_index = 5'd9; in_set = 1'b0;
      tick;
      in_valid = 1'b0;
      chk("unm9_onehot", oh1, 32'h0000_0200);
      tick;
      chk("unm9_count", cnt1, 0);
      chk("unm9_none", nm1, 1);
      chk("unm9_err1", err1, EXP_ERR);
      chk("unm9_err0", err0, EXP_ERR);
      chk("unm9_bm1", bm1_p, 32'h0000_0000);
      chk("unm9_onehot_off", oh1, 0);

      rst = 1'b1;
      tick;
      rst = 1'b0;
      chk("rst2_err", err1, 0);

      // Mark 5
      in_valid = 1'b1; in_index = 5'd5; in_set = 1'b1;
      chk("m5_ready", rdy1, 1);
      tick;
      in_valid = 1'b0;
      chk("m5_onehot", oh1, 32'h0000_0020);
      chk("m5_count_early", cnt1, 0);
      chk("m5_bm_early", bm1_p, 32'h0000_0000);
      tick;
      chk("m5_onehot_off", oh1, 0);
      chk("m5_count", cnt1, 1);
      chk("m5_count0", cnt0, 1);
      chk("m5_bm1", bm1_p, 32'h0000_0020);
      chk("m5_bm0", bm0_p, 32'hFFFF_FFDF);
      chk("m5_err", err1, 0);

      // Mark 7 twice back-to-back
      in_valid = 1'b1; in_index = 5'd7; in_set = 1'b1;
      tick;
      chk("m7a_onehot", oh1, 32'h0000_0080);
      tick;
      in_valid = 1'b0;
      chk("m7b_onehot", oh1, 32'h0000_0080);
      chk("m7b_count", cnt1, 2);
      chk("m7b_err", err1, 0);
      tick;
      chk("m7_count", cnt1, 2);
      chk("m7_err", err1, EXP_ERR);
      chk("m7_bm1", bm1_p, 32'h0000_00A0);
      chk("m7_onehot_off", oh1, 0);

      // Unmark 5; err stays sticky
      in_valid = 1'b1; in_index = 5'd5; in_set = 1'b0;
      tick;
      in_valid = 1'b0;
      tick;
      chk("u5_count", cnt1, 1);
      chk("u5_bm1", bm1_p, 32'h0000_0080);
      chk("u5_err_sticky", err1, EXP_ERR);

      // Mark 0..31 back-to-back (7 already marked)
      for (int i = 0; i < 32; i++) begin
         in_valid = 1'b1; in_index = 5'(i); in_set = 1'b1;
         chk("b2b_ready", rdy1, 1);
         tick;
      end
      in_valid = 1'b0;
      chk("b2b_count31", cnt1, 31);
      chk("b2b_all_early", am1, 0);
      chk("b2b_onehot31", oh1, 32'h8000_0000);
      tick;
      chk("b2b_count", cnt1, 32);
      chk("b2b_all1", am1, 1);
      chk("b2b_all0", am0, 1);
      chk("b2b_bm1", bm1_p, 32'hFFFF_FFFF);
      chk("b2b_bm0", bm0_p, 32'h0000_0000);
      chk("b2b_err", err1, EXP_ERR);

      // clear_all together with a request: clear wins
      clear_all = 1'b1; in_valid = 1'b1; in_index = 5'd3; in_set = 1'b0;
      #1;
      chk("clr_ready", rdy1, 0);
      tick;
      clear_all = 1'b0; in_valid = 1'b0;
      chk("clr_drain_busy", busy1, 1);
      chk("clr_drain_count", cnt1, 32);
      chk("clr_drain_onehot", oh1, 0);
      tick;
      chk("clr_g0_busy", busy1, 1);
      chk("clr_g0_count", cnt1, 32);
      clear_all = 1'b1;   // must be ignored while busy
      tick;
      clear_all = 1'b0;
      chk("clr_g1_count", cnt1, 24);
      chk("clr_g1_bm1", bm1_p, 32'hFFFF_FF00);
      chk("clr_g1_bm0", bm0_p, 32'h0000_00FF);
      tick;
      chk("clr_g2_count", cnt1, 16);
      chk("clr_g2_bm1", bm1_p, 32'hFFFF_0000);
      tick;
      chk("clr_g3_count", cnt1, 8);
      chk("clr_g3_busy", busy1, 1);
      chk("clr_g3_cdone", cd1, 0);
      tick;
      chk("clr_end_count", cnt1, 0);
      chk("clr_end_count0", cnt0, 0);
      chk("clr_end_busy", busy1, 0);
      chk("clr_end_cdone1", cd1, 1);
      chk("clr_end_cdone0", cd0, 1);
      chk("clr_end_err", err1, 0);
      chk("clr_end_none", nm1, 1);
      chk("clr_end_bm1", bm1_p, 32'h0000_0000);
      chk("clr_end_bm0", bm0_p, 32'hFFFF_FFFF);
      tick;
      chk("clr_after_cdone", cd1, 0);
      chk("clr_after_busy", busy1, 0);
      chk("clr_after_ready", rdy1, 1);

      // Reset during the second CLEAR cycle
      in_valid = 1'b1; in_index = 5'd20; in_set = 1'b1;
      tick;
      in_valid = 1'b0;
      tick;
      chk("m20_count", cnt1, 1);
      clear_all = 1'b1;
      tick;
      clear_all = 1'b0;
      tick;
      tick;
      chk("mid_busy", busy1, 1);
      chk("mid_count", cnt1, 1);
      rst = 1'b1;
      tick;
      rst = 1'b0;
      chk("mid_rst_busy", busy1, 0);
      chk("mid_rst_count", cnt1, 0);
      chk("mid_rst_bm1", bm1_p, 32'h0000_0000);
      chk("mid_rst_bm0", bm0_p, 32'hFFFF_FFFF);
      chk("mid_rst_cdone", cd1, 0);
      tick;
      chk("mid_post_cdone1", cd1, 0);
      chk("mid_post_cdone0", cd0, 0);
      chk("mid_post_busy", busy0, 0);
      chk("mid_post_count", cnt1, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/index_decoder_32.md
INDEX_DECODER_32 -- requirements
Module: index_decoder_32

Interface
REQ-001 Parameter SIGNAL, default 1, is the bitmap value meaning "marked"; the unmarked value is !SIGNAL.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 in_valid  input  1  request present on in_index/in_set.
REQ-005 in_ready  output  1  request accepted at the edge when in_valid && in_ready.
REQ-006 in_index  input  5  bitmap entry to update, 0..31.
REQ-007 in_set  input  1  1 = mark entry (write SIGNAL); 0 = unmark entry (write !SIGNAL).
REQ-008 clear_all  input  1  single-cycle pulse requesting that every entry be unmarked.
REQ-009 bitmap  output  unpacked [31:0] of 1-bit  registered entry states, index-compatible with the 32-input priority encoder data_inputs.
REQ-010 onehot  output  32  registered one-hot decode of the request held in the stage register; all-zero when the stage is empty.
REQ-011 count  output  6  registered number of marked entries, 0..32.
REQ-012 all_marked / none_marked  output  1 each  count==32 / count==0.
REQ-013 busy  output  1  high while the FSM is not IDLE.
REQ-014 clear_done  output  1  single-cycle pulse when a clear_all sequence completes.
REQ-015 err  output  1  sticky protocol-error flag.

Function
REQ-016 Two-stage pipeline: accept edge E loads the stage register (index, set, valid) and onehot; edge E+1 writes bitmap[index] and updates count.
REQ-017 in_ready = (state==IDLE) && !clear_all, combinationally; the stage register accepts back-to-back requests every cycle.
REQ-018 Back-to-back requests to the same index apply in acceptance order; the second request observes the first request's result for count and err purposes.
REQ-019 Count rules: +1 on a mark of an unmarked entry; -1 on an unmark of a marked entry; unchanged on a redundant operation; never wraps below 0 or above 32.
REQ-020 A redundant operation (mark of a marked entry or unmark of an unmarked entry) leaves bitmap unchanged and sets err.
REQ-021 FSM states: IDLE, DRAIN, CLEAR. IDLE->DRAIN on clear_all. DRAIN->CLEAR after one cycle, during which any stage-register request is applied. CLEAR->IDLE after 4 cycles.
REQ-022 In CLEAR, a 2-bit counter selects group g = 0..3; each cycle unmarks entries 8g..8g+7, and count is decremented by the number of entries in that group that were marked.
REQ-023 clear_done pulses on the cycle after the final CLEAR cycle, with state==IDLE, count==0, and every bitmap entry equal to !SIGNAL.
REQ-024 When clear_all and in_valid are asserted in the same cycle, clear_all wins and the request is not accepted.
REQ-025 clear_all is ignored while busy is high.
REQ-026 onehot returns to zero on the cycle after the stage register applies its request, unless a new request was accepted.

Reset
REQ-027 When rst is high at an edge, the following values load, overriding all other activity including a mid-CLEAR sequence: bitmap all !SIGNAL, count 0, onehot 0, stage register empty, state IDLE, group counter 0, err 0, clear_done 0.
REQ-028 Out of reset: in_ready=1, busy=0, none_marked=1, all_marked=0.

Configuration
REQ-029 With macro INDEX_DECODER_ERR_CHECK_EN defined, err is implemented per REQ-020, and is cleared by rst or at completion of a clear_all sequence.
REQ-030 With INDEX_DECODER_ERR_CHECK_EN undefined, err is tied to 0 and redundant operations silently leave bitmap and count unchanged.

Verification
REQ-031 Reset, then mark index 5 (SIGNAL=1) -> onehot=32'h20 one cycle after accept; bitmap[5]=1 and count=1 two cycles after accept; err=0.
REQ-032 Mark indices 0..31 back-to-back, one per cycle -> in_ready stays 1; count reaches 32 and all_marked=1 two cycles after the last accept.
REQ-033 With all 32 entries marked, pulse clear_all together with in_valid (index 3) -> request not accepted; busy high for 5 cycles; count steps 32,24,16,8,0; clear_done pulses once; bitmap all 0.
REQ-034 Mark 7 twice (macro defined) -> count=1 and err=1; err stays 1 until a clear_all completes. Repeat with macro undefined -> err=0.
REQ-035 Unmark 9 at reset state -> count stays 0, none_marked=1; err=1 only with the macro defined.
REQ-036 Assert rst on the second CLEAR cycle -> the next cycle shows state IDLE, count 0, bitmap all !SIGNAL, and no clear_done pulse; repeat with SIGNAL=0 and check that the bitmap reset value is all 1.
